// File: rtl/result_drain.sv
// Result read-out unit: snapshots CH flattened NxN result matrices on start and
// streams each element over valid/ready tagged with ch/row/col. Checksum: RESULT_DRAIN_CKSUM_EN.
module result_drain #(
  parameter  int unsigned N   = 3,
  parameter  int unsigned W   = 8,
  parameter  int unsigned CH  = 2,
  localparam int unsigned NE  = CH * N * N,
  localparam int unsigned CW  = (CH > 1) ? $clog2(CH) : 1,
  localparam int unsigned IW  = (N > 1) ? $clog2(N) : 1,
  localparam int unsigned EW  = (NE > 1) ? $clog2(NE) : 1,
  localparam int unsigned CKW = W + $clog2(NE + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [NE*W-1:0]   res_flat_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [W-1:0]      out_data_o,
  output logic [CW-1:0]     out_ch_o,
  output logic [IW-1:0]     out_row_o,
  output logic [IW-1:0]     out_col_o,
  output logic              out_last_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [1:0]        status_o,
  output logic [CKW-1:0]    cksum_o
);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  buf_q [NE];
  logic [EW-1:0] idx_q, idx_d, idx_nx;
  logic [CW-1:0] ch_q, ch_d, ch_nx;
  logic [IW-1:0] row_q, row_d, row_nx;
  logic [IW-1:0] col_q, col_d, col_nx;
  logic [W-1:0]  data_q, data_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [1:0]    status_q, status_d;
  logic          accept_c, hs_c;

  assign accept_c = (state_q == S_IDLE) && start_i;
  assign hs_c     = valid_q && out_ready_i;

  // Snapshot buffer; contents are irrelevant until a start captures them.
  always_ff @(posedge clk) begin
    if (accept_c) begin
      for (int unsigned e = 0; e < NE; e++) begin
        buf_q[e] <= res_flat_i[e*W +: W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_DRAIN;
      S_DRAIN: if (hs_c && last_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Successor of the current element: col fastest, then row, then channel.
  always_comb begin
    idx_nx = idx_q + EW'(1);
    ch_nx  = ch_q;
    row_nx = row_q;
    col_nx = col_q + IW'(1);
    if (col_q == IW'(N - 1)) begin
      col_nx = '0;
      row_nx = row_q + IW'(1);
      if (row_q == IW'(N - 1)) begin
        row_nx = '0;
        ch_nx  = ch_q + CW'(1);
      end
    end
  end

  always_comb begin
    idx_d    = idx_q;
    ch_d     = ch_q;
    row_d    = row_q;
    col_d    = col_q;
    data_d   = data_q;
    valid_d  = valid_q;
    last_d   = last_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    status_d = status_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          idx_d    = '0;
          ch_d     = '0;
          row_d    = '0;
          col_d    = '0;
          data_d   = res_flat_i[W-1:0];
          valid_d  = 1'b1;
          last_d   = (NE == 1);
          busy_d   = 1'b1;
          status_d = 2'b01;
        end
      end
      S_DRAIN: begin
        if (hs_c) begin
          if (last_q) begin
            valid_d  = 1'b0;
            last_d   = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            status_d = 2'b10;
          end else begin
            idx_d  = idx_nx;
            ch_d   = ch_nx;
            row_d  = row_nx;
            col_d  = col_nx;
            data_d = buf_q[idx_nx];
            last_d = (idx_nx == EW'(NE - 1));
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q    <= '0;
      ch_q     <= '0;
      row_q    <= '0;
      col_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      status_q <= 2'b00;
    end else begin
      idx_q    <= idx_d;
      ch_q     <= ch_d;
      row_q    <= row_d;
      col_q    <= col_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      status_q <= status_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_ch_o    = ch_q;
  assign out_row_o   = row_q;
  assign out_col_o   = col_q;
  assign out_last_o  = last_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign status_o    = status_q;

`ifdef RESULT_DRAIN_CKSUM_EN
  logic [CKW-1:0] cksum_q, cksum_d;

  // Running sum of accepted beats; wide enough that it cannot wrap.
  always_comb begin
    cksum_d = cksum_q;
    if (accept_c)  cksum_d = '0;
    else if (hs_c) cksum_d = cksum_q + CKW'(data_q);
  end

  always_ff @(posedge clk) begin
    if (rst) cksum_q <= '0;
    else     cksum_q <= cksum_d;
  end

  assign cksum_o = cksum_q;
`else
  assign cksum_o = '0;
`endif

endmodule

// File: tb/tb_result_drain.sv
// Directed bench for result_drain: a 2x2x2-channel instance and a 3x3 single-channel 16-bit instance.
`timescale 1ns/1ps
module tb_result_drain;

  localparam int unsigned N = 2, W = 8, CH = 2;
`ifdef RESULT_DRAIN_CKSUM_EN
  localparam logic [11:0] EXP_CK  = 12'd36;
  localparam logic [19:0] EXP_CK3 = 20'h8FFF7;
`else
  localparam logic [11:0] EXP_CK  = 12'd0;
  localparam logic [19:0] EXP_CK3 = 20'h0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, start, out_ready;
  logic [CH*N*N*W-1:0]  res_flat;
  logic                 out_valid, out_last, busy, done;
  logic [W-1:0]         out_data;
  logic [0:0]           out_ch, out_row, out_col;
  logic [1:0]           status;
  logic [11:0]          cksum;

  logic                 start3, ready3;
  logic [143:0]         res3;
  logic                 valid3, last3, busy3, done3;
  logic [15:0]          data3;
  logic [0:0]           ch3;
  logic [1:0]           row3, col3;
  logic [1:0]           status3;
  logic [19:0]          cksum3;

  int errors = 0;
  int checks = 0;

  result_drain #(.N(N), .W(W), .CH(CH)) u_dut (
    .clk(clk), .rst(rst), .start_i(start), .res_flat_i(res_flat),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_ch_o(out_ch), .out_row_o(out_row), .out_col_o(out_col),
    .out_last_o(out_last), .busy_o(busy), .done_o(done),
    .status_o(status), .cksum_o(cksum)
  );

  result_drain #(.N(3), .W(16), .CH(1)) u_dut3 (
    .clk(clk), .rst(rst), .start_i(start3), .res_flat_i(res3),
    .out_valid_o(valid3), .out_ready_i(ready3), .out_data_o(data3),
    .out_ch_o(ch3), .out_row_o(row3), .out_col_o(col3),
    .out_last_o(last3), .busy_o(busy3), .done_o(done3),
    .status_o(status3), .cksum_o(cksum3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ramp();
    for (int e = 0; e < 8; e++) res_flat[e*8 +: 8] = 8'(e + 1);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; out_ready = 1'b1; start3 = 1'b0; ready3 = 1'b1;
    res_flat = '0; res3 = '0;
    step(); step();
    checks++;
    if ({out_valid, busy, done, status, cksum, out_data, out_ch, out_row, out_col, out_last} !== '0)
      begin errors++; $display("FAIL reset_outputs: got %h want 0",
        {out_valid, busy, done, status, cksum, out_data, out_ch, out_row, out_col, out_last}); end
    checks++;
    if ({valid3, busy3, done3, status3, cksum3, data3, ch3, row3, col3, last3} !== '0)
      begin errors++; $display("FAIL reset_outputs3: got %h want 0",
        {valid3, busy3, done3, status3, cksum3, data3, ch3, row3, col3, last3}); end
    rst = 1'b0;
    step();
    checks++;
    if ({out_valid, status} !== 3'b000)
      begin errors++; $display("FAIL idle_after_reset: got %b want 000", {out_valid, status}); end
  endtask

  task automatic test_basic();
    logic [15:0] exp_v, got_v;
    load_ramp(); out_ready = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    for (int b = 0; b < 8; b++) begin
      exp_v = {1'b1, 8'(b + 1), 1'(b >> 2), 1'(b >> 1), 1'(b), (b == 7), 1'b1, 2'b01};
      got_v = {out_valid, out_data, out_ch, out_row, out_col, out_last, busy, status};
      checks++;
      if (got_v !== exp_v)
        begin errors++; $display("FAIL basic_beat%0d: got %h want %h", b, got_v, exp_v); end
      step();
    end
    checks++;
    if ({done, out_valid, busy, status} !== 5'b10010)
      begin errors++; $display("FAIL basic_done: got %b want 10010", {done, out_valid, busy, status}); end
    checks++;
    if (cksum !== EXP_CK)
      begin errors++; $display("FAIL basic_cksum: got %0d want %0d", cksum, EXP_CK); end
    step();
    checks++;
    if ({done, out_valid, status} !== 4'b0010)
      begin errors++; $display("FAIL basic_after_done: got %b want 0010", {done, out_valid, status}); end
    checks++;
    if (cksum !== EXP_CK)
      begin errors++; $display("FAIL basic_cksum_hold: got %0d want %0d", cksum, EXP_CK); end
  endtask

  task automatic test_backpressure();
    int b, stalls, cyc;
    load_ramp(); out_ready = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    b = 0; stalls = 0; cyc = 1;
    while (done !== 1'b1 && cyc < 60) begin
      if (out_valid === 1'b1) begin
        checks++;
        if ({out_data, out_ch, out_row, out_col, out_last} !== {8'(b + 1), 1'(b >> 2), 1'(b >> 1), 1'(b), (b == 7)})
          begin errors++; $display("FAIL bp_payload cyc%0d: got %h want beat %0d",
            cyc, {out_data, out_ch, out_row, out_col, out_last}, b + 1); end
      end
      out_ready = (cyc % 3 == 1);
      if (out_valid === 1'b1 && out_ready) b++;
      else if (out_valid === 1'b1) stalls++;
      step(); cyc++;
    end
    out_ready = 1'b1;
    checks++;
    if (done !== 1'b1 || b != 8)
      begin errors++; $display("FAIL bp_complete: got done=%b beats=%0d want done=1 beats=8", done, b); end
    checks++;
    if (stalls != 14 || cyc != 9 + stalls)
      begin errors++; $display("FAIL bp_latency: got cyc=%0d stalls=%0d want cyc=23 stalls=14", cyc, stalls); end
    step();
  endtask

  task automatic test_capture();
    load_ramp(); out_ready = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    res_flat = '1;
    for (int b = 0; b < 8; b++) begin
      checks++;
      if ({out_valid, out_data} !== {1'b1, 8'(b + 1)})
        begin errors++; $display("FAIL capture_beat%0d: got %h want %h", b, {out_valid, out_data}, {1'b1, 8'(b + 1)}); end
      step();
    end
    checks++;
    if ({done, cksum} !== {1'b1, EXP_CK})
      begin errors++; $display("FAIL capture_done: got %h want %h", {done, cksum}, {1'b1, EXP_CK}); end
    step();
  endtask

  task automatic test_restart_ignored();
    int beats, dones;
    load_ramp(); out_ready = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    beats = 0; dones = 0;
    for (int c = 0; c < 14; c++) begin
      start = (out_valid === 1'b1) && (beats == 2 || beats == 7);
      if (out_valid === 1'b1) beats++;
      if (done === 1'b1) dones++;
      step();
    end
    start = 1'b0;
    checks++;
    if (beats != 8 || dones != 1)
      begin errors++; $display("FAIL restart_ignored: got beats=%0d dones=%0d want 8 and 1", beats, dones); end
    checks++;
    if ({out_valid, busy, status} !== 4'b0010)
      begin errors++; $display("FAIL restart_idle: got %b want 0010", {out_valid, busy, status}); end
  endtask

  task automatic test_reset_mid();
    load_ramp(); out_ready = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    repeat (4) step();
    out_ready = 1'b0;
    step();
    checks++;
    if ({out_valid, out_data, out_ch, out_row, out_col} !== {1'b1, 8'd5, 1'b1, 1'b0, 1'b0})
      begin errors++; $display("FAIL mid_stall_beat5: got %h want %h",
        {out_valid, out_data, out_ch, out_row, out_col}, {1'b1, 8'd5, 1'b1, 1'b0, 1'b0}); end
    rst = 1'b1; step(); rst = 1'b0;
    checks++;
    if ({out_valid, busy, done, status, cksum, out_data, out_ch, out_row, out_col, out_last} !== '0)
      begin errors++; $display("FAIL mid_reset_outputs: got %h want 0",
        {out_valid, busy, done, status, cksum, out_data, out_ch, out_row, out_col, out_last}); end
    out_ready = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    checks++;
    if ({out_valid, out_data, out_ch, out_row, out_col, out_last, status} !== {1'b1, 8'd1, 4'b0000, 2'b01})
      begin errors++; $display("FAIL mid_restart_first: got %h want %h",
        {out_valid, out_data, out_ch, out_row, out_col, out_last, status}, {1'b1, 8'd1, 4'b0000, 2'b01}); end
    repeat (8) step();
    checks++;
    if ({done, cksum} !== {1'b1, EXP_CK})
      begin errors++; $display("FAIL mid_restart_done: got %h want %h", {done, cksum}, {1'b1, EXP_CK}); end
    step();
  endtask

  task automatic test_n3();
    logic [22:0] exp_v, got_v;
    res3 = '1; ready3 = 1'b1;
    start3 = 1'b1; step(); start3 = 1'b0;
    for (int b = 0; b < 9; b++) begin
      exp_v = {1'b1, 16'hFFFF, 1'b0, 2'(b / 3), 2'(b % 3), (b == 8)};
      got_v = {valid3, data3, ch3, row3, col3, last3};
      checks++;
      if (got_v !== exp_v)
        begin errors++; $display("FAIL n3_beat%0d: got %h want %h", b, got_v, exp_v); end
      step();
    end
    checks++;
    if ({done3, valid3, status3} !== 4'b1010)
      begin errors++; $display("FAIL n3_done: got %b want 1010", {done3, valid3, status3}); end
    checks++;
    if (cksum3 !== EXP_CK3)
      begin errors++; $display("FAIL n3_cksum: got %h want %h", cksum3, EXP_CK3); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_capture();
    test_restart_ignored();
    test_reset_mid();
    test_n3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
